// File: rtl/port_rx_writer_pkg.sv
// Shared constants, descriptor layout and CRC-32 helpers for the per-port ingress writer.
package port_rx_writer_pkg;

    localparam int unsigned DEF_MAX_LEN    = 1518;
    localparam int unsigned DEF_MIN_LEN    = 64;
    localparam int unsigned DEF_DATA_DEPTH = 4096;
    localparam int unsigned DEF_CNT_W      = 12;

    localparam int unsigned LEN_W   = 13;
    localparam int unsigned DESC_W  = 16;

    localparam int unsigned SHORT_BIT = 15;
    localparam int unsigned LONG_BIT  = 14;
    localparam int unsigned ERR_BIT   = 13;
    localparam int unsigned LEN_MSB   = 12;

    localparam logic [31:0] CRC32_INIT     = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_RESIDUE  = 32'hC704_DD7B;
    localparam logic [31:0] CRC32_POLY_REF = 32'hEDB8_8320;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RECV   = 3'd1,
        ST_DROP   = 3'd2,
        ST_PAD    = 3'd3,
        ST_COMMIT = 3'd4
    } state_t;

    // Descriptor word written to the pointer FIFO once per frame.
    typedef struct packed {
        logic             is_short;
        logic             is_long;
        logic             err;
        logic [LEN_W-1:0] len;
    } rx_desc_t;

    // One byte of the LSB-first (reflected) CRC-32.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY_REF) : (c >> 1);
        end
        return c;
    endfunction

    // The reflected register holds the residue bit-reversed.
    function automatic logic [31:0] bitrev32(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = x[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/port_rx_writer_crc32_d8.sv
// Byte-wide reflected CRC-32 (poly 0x04C11DB7) with init/enable and a residue check.
module crc32_d8
    import port_rx_writer_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       i_init,
    input  logic       i_en,
    input  logic [7:0] i_data,
    output logic       o_residue_ok_c
);

    logic [31:0] r_crc;

    // i_init together with i_en seeds the register and folds in the first byte.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_crc <= CRC32_INIT;
        end else if (i_en) begin
            r_crc <= crc32_byte(i_init ? CRC32_INIT : r_crc, i_data);
        end else if (i_init) begin
            r_crc <= CRC32_INIT;
        end
    end

    assign o_residue_ok_c = (bitrev32(r_crc) == CRC32_RESIDUE);

endmodule

// File: rtl/port_rx_writer.sv
// Per-port ingress: admits MAC frames, writes bytes to the rx data FIFO, pads runts,
// checks CRC-32 and posts one descriptor per admitted frame to the pointer FIFO.
module port_rx_writer
    import port_rx_writer_pkg::*;
#(
    parameter int unsigned MAX_LEN    = DEF_MAX_LEN,
    parameter int unsigned MIN_LEN    = DEF_MIN_LEN,
    parameter int unsigned DATA_DEPTH = DEF_DATA_DEPTH,
    parameter int unsigned CNT_W      = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              rx_dv,
    input  logic [7:0]        rx_data,
    input  logic              rx_er,
    output logic              data_fifo_wr,
    output logic [7:0]        data_fifo_din,
    input  logic [CNT_W-1:0]  data_fifo_cnt,
    output logic              ptr_fifo_wr,
    output logic [DESC_W-1:0] ptr_fifo_din,
    input  logic              ptr_fifo_full,
    output logic [15:0]       frame_cnt,
    output logic [15:0]       drop_cnt
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(MIN_LEN);

    state_t           r_state;
    logic [LEN_W-1:0] r_len;
    logic             r_short;
    logic             r_long;
    logic             r_err;
    logic             r_head_lost;

    logic             w_admit;
    logic             w_crc_init;
    logic             w_crc_en;
    logic             w_residue_ok;
    rx_desc_t         w_desc;

    // Reserve a full MAX_LEN of space up front so nothing can overflow mid-frame.
    assign w_admit    = !ptr_fifo_full &&
                        ((32'(DATA_DEPTH) - 32'(data_fifo_cnt)) >= 32'(MAX_LEN));
    assign w_crc_init = (r_state == ST_IDLE) && rx_dv && w_admit;
    assign w_crc_en   = w_crc_init || ((r_state == ST_RECV) && rx_dv);

    assign w_desc.is_short = r_short;
    assign w_desc.is_long  = r_long;
    assign w_desc.err      = r_err;
    assign w_desc.len      = r_len;

    crc32_d8 u_crc (
        .clk            (clk),
        .rstn           (rstn),
        .i_init         (w_crc_init),
        .i_en           (w_crc_en),
        .i_data         (rx_data),
        .o_residue_ok_c (w_residue_ok)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state       <= ST_IDLE;
            r_len         <= '0;
            r_short       <= 1'b0;
            r_long        <= 1'b0;
            r_err         <= 1'b0;
            r_head_lost   <= 1'b0;
            data_fifo_wr  <= 1'b0;
            data_fifo_din <= '0;
            ptr_fifo_wr   <= 1'b0;
            ptr_fifo_din  <= '0;
            frame_cnt     <= '0;
            drop_cnt      <= '0;
        end else begin
            data_fifo_wr <= 1'b0;
            ptr_fifo_wr  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (rx_dv) begin
                        if (w_admit) begin
                            data_fifo_wr  <= 1'b1;
                            data_fifo_din <= rx_data;
                            r_len         <= LEN_W'(1);
                            r_short       <= 1'b0;
                            r_long        <= 1'b0;
                            r_err         <= rx_er;
                            r_head_lost   <= 1'b0;
                            r_state       <= ST_RECV;
                        end else begin
                            drop_cnt <= drop_cnt + 16'd1;
                            r_state  <= ST_DROP;
                        end
                    end
                end
                ST_RECV: begin
                    if (rx_dv) begin
                        if (r_len < LEN_MAX) begin
                            data_fifo_wr  <= 1'b1;
                            data_fifo_din <= rx_data;
                            r_len         <= r_len + LEN_W'(1);
                        end else begin
                            r_long <= 1'b1;
                        end
                        if (rx_er) begin
                            r_err <= 1'b1;
                        end
                    end else begin
                        if (!w_residue_ok) begin
                            r_err <= 1'b1;
                        end
                        if (r_len < LEN_MIN) begin
                            r_short <= 1'b1;
                            r_state <= ST_PAD;
                        end else begin
                            r_state <= ST_COMMIT;
                        end
                    end
                end
                ST_PAD: begin
                    data_fifo_wr  <= 1'b1;
                    data_fifo_din <= 8'h00;
                    r_len         <= r_len + LEN_W'(1);
                    if (r_len + LEN_W'(1) == LEN_MIN) begin
                        r_state <= ST_COMMIT;
                    end
                    if (rx_dv) begin
                        r_head_lost <= 1'b1;
                    end
                end
                ST_COMMIT: begin
                    ptr_fifo_wr  <= 1'b1;
                    ptr_fifo_din <= w_desc;
                    frame_cnt    <= frame_cnt + 16'd1;
                    r_head_lost  <= 1'b0;
                    // A frame that started during PAD/COMMIT is headless; swallow the rest.
                    if (r_head_lost || rx_dv) begin
                        drop_cnt <= drop_cnt + 16'd1;
                        r_state  <= ST_DROP;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (!rx_dv) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_port_rx_writer.sv
// Randomized bench for port_rx_writer, checked against a frame-level reference model.
module tb_port_rx_writer;

    localparam int M_MAX_LEN = 1518;
    localparam int M_MIN_LEN = 64;
    localparam int M_DEPTH   = 4096;

    logic        clk = 1'b0;
    logic        rstn;
    logic        rx_dv;
    logic [7:0]  rx_data;
    logic        rx_er;
    logic        data_fifo_wr;
    logic [7:0]  data_fifo_din;
    logic [11:0] data_fifo_cnt;
    logic        ptr_fifo_wr;
    logic [15:0] ptr_fifo_din;
    logic        ptr_fifo_full;
    logic [15:0] frame_cnt;
    logic [15:0] drop_cnt;

    always #5 clk = ~clk;

    port_rx_writer dut (
        .clk           (clk),
        .rstn          (rstn),
        .rx_dv         (rx_dv),
        .rx_data       (rx_data),
        .rx_er         (rx_er),
        .data_fifo_wr  (data_fifo_wr),
        .data_fifo_din (data_fifo_din),
        .data_fifo_cnt (data_fifo_cnt),
        .ptr_fifo_wr   (ptr_fifo_wr),
        .ptr_fifo_din  (ptr_fifo_din),
        .ptr_fifo_full (ptr_fifo_full),
        .frame_cnt     (frame_cnt),
        .drop_cnt      (drop_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int exp_frames = 0;
    int exp_drops  = 0;

    logic [7:0]  q_data[$];
    logic [15:0] q_ptr[$];
    int          q_ptr_ndata[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Capture every FIFO write; each descriptor remembers how many data bytes preceded it.
    always @(negedge clk) begin
        if (data_fifo_wr) q_data.push_back(data_fifo_din);
        if (ptr_fifo_wr) begin
            q_ptr.push_back(ptr_fifo_din);
            q_ptr_ndata.push_back(q_data.size());
        end
    end

    // Bit-serial Ethernet FCS over the first n bytes.
    function automatic logic [31:0] ref_fcs(input logic [7:0] b[$], input int n);
        logic [31:0] crc = 32'hFFFF_FFFF;
        logic        fb;
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 8; k++) begin
                fb  = crc[0] ^ b[i][k];
                crc = crc >> 1;
                if (fb) crc = crc ^ 32'hEDB8_8320;
            end
        end
        return ~crc;
    endfunction

    task automatic make_frame(input int len, input bit corrupt, output logic [7:0] f[$]);
        logic [31:0] fcs;
        f.delete();
        for (int i = 0; i < len - 4; i++) f.push_back(8'($urandom));
        fcs = ref_fcs(f, len - 4);
        for (int i = 0; i < 4; i++) f.push_back(fcs[8*i +: 8]);
        if (corrupt) f[len-1] = f[len-1] ^ 8'h5A;
    endtask

    task automatic run_frame(input string tag, input logic [7:0] f[$], input int er_idx,
                             input logic [11:0] cnt);
        int          len;
        int          nw;
        bit          admit;
        bit          err;
        logic [7:0]  exp_q[$];
        logic [31:0] fcs_rx;
        logic [15:0] exp_desc;
        int          mm;
        len = f.size();
        q_data.delete();
        q_ptr.delete();
        q_ptr_ndata.delete();
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            if (i == 0) data_fifo_cnt = cnt;
            rx_dv   = 1'b1;
            rx_data = f[i];
            rx_er   = (i == er_idx);
        end
        @(negedge clk);
        rx_dv   = 1'b0;
        rx_er   = 1'b0;
        rx_data = 8'h00;
        repeat (80) @(negedge clk);

        admit = (M_DEPTH - int'(cnt)) >= M_MAX_LEN;
        nw    = (len < M_MAX_LEN) ? len : M_MAX_LEN;
        exp_q.delete();
        if (admit) begin
            for (int i = 0; i < nw; i++) exp_q.push_back(f[i]);
            while (exp_q.size() < M_MIN_LEN) exp_q.push_back(8'h00);
            exp_frames++;
        end else begin
            exp_drops++;
        end
        fcs_rx   = {f[len-1], f[len-2], f[len-3], f[len-4]};
        err      = (er_idx >= 0 && er_idx < len) || (ref_fcs(f, len - 4) != fcs_rx);
        exp_desc = {(len < M_MIN_LEN), (len > M_MAX_LEN), err, 13'(exp_q.size())};

        check_val({tag, ".ndata"}, 32'(q_data.size()), 32'(exp_q.size()));
        mm = -1;
        for (int i = 0; i < q_data.size() && i < exp_q.size(); i++) begin
            if (q_data[i] !== exp_q[i]) begin
                mm = i;
                break;
            end
        end
        check_val({tag, ".first_bad_byte"}, 32'(mm), 32'hFFFF_FFFF);
        check_val({tag, ".nptr"}, 32'(q_ptr.size()), admit ? 32'd1 : 32'd0);
        if (admit && q_ptr.size() > 0) begin
            check_val({tag, ".desc"}, 32'(q_ptr[0]), 32'(exp_desc));
            check_val({tag, ".bytes_before_desc"}, 32'(q_ptr_ndata[0]), 32'(exp_q.size()));
        end
        check_val({tag, ".frame_cnt"}, 32'(frame_cnt), 32'(16'(exp_frames)));
        check_val({tag, ".drop_cnt"}, 32'(drop_cnt), 32'(16'(exp_drops)));
    endtask

    initial begin
        logic [7:0] f[$];
        int         len;
        int         er;
        logic [11:0] cnt;

        rstn = 1'b0;
        rx_dv = 1'b0;
        rx_data = 8'h00;
        rx_er = 1'b0;
        data_fifo_cnt = 12'd0;
        ptr_fifo_full = 1'b0;
        repeat (3) @(negedge clk);
        check_val("reset.data_wr", 32'(data_fifo_wr), 32'd0);
        check_val("reset.data_din", 32'(data_fifo_din), 32'd0);
        check_val("reset.ptr_wr", 32'(ptr_fifo_wr), 32'd0);
        check_val("reset.ptr_din", 32'(ptr_fifo_din), 32'd0);
        check_val("reset.frame_cnt", 32'(frame_cnt), 32'd0);
        check_val("reset.drop_cnt", 32'(drop_cnt), 32'd0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        make_frame(64, 1'b0, f);   run_frame("f64_ok", f, -1, 12'd0);
        make_frame(100, 1'b1, f);  run_frame("f100_badfcs", f, -1, 12'd0);
        make_frame(40, 1'b0, f);   run_frame("f40_runt", f, -1, 12'd0);
        make_frame(2000, 1'b0, f); run_frame("f2000_long", f, -1, 12'd0);
        make_frame(100, 1'b0, f);  run_frame("full_fifo_drop", f, -1, 12'd3000);
        make_frame(64, 1'b0, f);   run_frame("after_drop", f, -1, 12'd0);
        make_frame(64, 1'b0, f);   run_frame("rx_er_b10", f, 10, 12'd0);
        make_frame(70, 1'b0, f);   run_frame("cnt_edge_ok", f, -1, 12'd2578);
        make_frame(70, 1'b0, f);   run_frame("cnt_edge_drop", f, -1, 12'd2579);
        make_frame(1518, 1'b0, f); run_frame("f1518_exact", f, -1, 12'd0);
        make_frame(1519, 1'b0, f); run_frame("f1519_over", f, -1, 12'd0);

        for (int n = 0; n < 25; n++) begin
            len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1510, 1530))
                                              : int'($urandom_range(5, 200));
            make_frame(len, $urandom_range(0, 3) == 0, f);
            er  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            cnt = ($urandom_range(0, 5) == 0) ? 12'($urandom_range(2579, 4095))
                                              : 12'($urandom_range(0, 2578));
            run_frame($sformatf("rnd%0d", n), f, er, cnt);
        end

        // Reset in the middle of a frame: everything clears on the next edge.
        make_frame(80, 1'b0, f);
        data_fifo_cnt = 12'd0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            rx_dv   = 1'b1;
            rx_data = f[i];
        end
        check_val("midreset.wr_before", 32'(data_fifo_wr), 32'd1);
        rstn = 1'b0;
        @(negedge clk);
        check_val("midreset.data_wr", 32'(data_fifo_wr), 32'd0);
        check_val("midreset.data_din", 32'(data_fifo_din), 32'd0);
        check_val("midreset.frame_cnt", 32'(frame_cnt), 32'd0);
        check_val("midreset.drop_cnt", 32'(drop_cnt), 32'd0);
        rx_dv = 1'b0;
        rstn  = 1'b1;
        exp_frames = 0;
        exp_drops  = 0;
        repeat (3) @(negedge clk);
        make_frame(64, 1'b0, f);   run_frame("post_reset", f, -1, 12'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
